// File: rtl/axi_mm_a32_d128_packet_gen1_master_name_if.sv
// Bundles the user AXI channels and the Logic Link FIFO channels of the master-side packet gen.
// The master modport is the packet gen's view. The slave modport is the view of the user master and link FIFOs.
interface axi_mm_a32_d128_packet_gen1_master_name_if;
  localparam int AR_W = 49;
  localparam int AW_W = 49;
  localparam int W_W  = 149;
  localparam int R_W  = 135;
  localparam int B_W  = 6;

  logic [3:0]      user_arid;
  logic [2:0]      user_arsize;
  logic [7:0]      user_arlen;
  logic [1:0]      user_arburst;
  logic [31:0]     user_araddr;
  logic            user_arvalid;
  logic            user_arready;

  logic [3:0]      user_awid;
  logic [2:0]      user_awsize;
  logic [7:0]      user_awlen;
  logic [1:0]      user_awburst;
  logic [31:0]     user_awaddr;
  logic            user_awvalid;
  logic            user_awready;

  logic [3:0]      user_wid;
  logic [127:0]    user_wdata;
  logic [15:0]     user_wstrb;
  logic            user_wlast;
  logic            user_wvalid;
  logic            user_wready;

  logic [3:0]      user_rid;
  logic [127:0]    user_rdata;
  logic            user_rlast;
  logic [1:0]      user_rresp;
  logic            user_rvalid;
  logic            user_rready;

  logic [3:0]      user_bid;
  logic [1:0]      user_bresp;
  logic            user_bvalid;
  logic            user_bready;

  logic            user_ar_valid;
  logic [AR_W-1:0] txfifo_ar_data;
  logic            user_ar_ready;
  logic            user_aw_valid;
  logic [AW_W-1:0] txfifo_aw_data;
  logic            user_aw_ready;
  logic            user_w_valid;
  logic [W_W-1:0]  txfifo_w_data;
  logic            user_w_ready;
  logic            user_r_valid;
  logic [R_W-1:0]  rxfifo_r_data;
  logic            user_r_ready;
  logic            user_b_valid;
  logic [B_W-1:0]  rxfifo_b_data;
  logic            user_b_ready;

  modport master (
    input  user_arid, user_arsize, user_arlen, user_arburst, user_araddr, user_arvalid,
    output user_arready,
    input  user_awid, user_awsize, user_awlen, user_awburst, user_awaddr, user_awvalid,
    output user_awready,
    input  user_wid, user_wdata, user_wstrb, user_wlast, user_wvalid,
    output user_wready,
    output user_rid, user_rdata, user_rlast, user_rresp, user_rvalid,
    input  user_rready,
    output user_bid, user_bresp, user_bvalid,
    input  user_bready,
    output user_ar_valid, txfifo_ar_data,
    input  user_ar_ready,
    output user_aw_valid, txfifo_aw_data,
    input  user_aw_ready,
    output user_w_valid, txfifo_w_data,
    input  user_w_ready,
    input  user_r_valid, rxfifo_r_data,
    output user_r_ready,
    input  user_b_valid, rxfifo_b_data,
    output user_b_ready
  );

  modport slave (
    output user_arid, user_arsize, user_arlen, user_arburst, user_araddr, user_arvalid,
    input  user_arready,
    output user_awid, user_awsize, user_awlen, user_awburst, user_awaddr, user_awvalid,
    input  user_awready,
    output user_wid, user_wdata, user_wstrb, user_wlast, user_wvalid,
    input  user_wready,
    input  user_rid, user_rdata, user_rlast, user_rresp, user_rvalid,
    output user_rready,
    input  user_bid, user_bresp, user_bvalid,
    output user_bready,
    input  user_ar_valid, txfifo_ar_data,
    output user_ar_ready,
    input  user_aw_valid, txfifo_aw_data,
    output user_aw_ready,
    input  user_w_valid, txfifo_w_data,
    output user_w_ready,
    output user_r_valid, rxfifo_r_data,
    input  user_r_ready,
    output user_b_valid, rxfifo_b_data,
    input  user_b_ready
  );
endinterface

// File: rtl/axi_mm_a32_d128_packet_gen1_master_name.sv
// Master-side Logic Link packetizer: packs AR/AW/W into TX words and unpacks R/B from RX words.
// Every channel is decoupled by a 2-entry skid buffer whose outputs are all registered.
module axi_mm_a32_d128_packet_gen1_master_name_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);
  logic [W-1:0] mem [2];
  logic [1:0]   count;
  logic [1:0]   count_nxt;
  logic         head;
  logic         tail;
  logic         head_nxt;
  logic         accept;
  logic         issue;

  always_comb begin
    accept    = up_valid & up_ready;
    issue     = dn_valid & dn_ready;
    count_nxt = count + {1'b0, accept} - {1'b0, issue};
    head_nxt  = head ^ issue;
  end

  // Outputs are computed from next-state so an accepted word is presented on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      count    <= 2'd0;
      head     <= 1'b0;
      tail     <= 1'b0;
      up_ready <= 1'b0;
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else begin
      if (accept) begin
        mem[tail] <= up_data;
      end
      tail     <= tail ^ accept;
      head     <= head_nxt;
      count    <= count_nxt;
      up_ready <= (count_nxt != 2'd2);
      dn_valid <= (count_nxt != 2'd0);
      if (count_nxt != 2'd0) begin
        dn_data <= (accept && (tail == head_nxt)) ? up_data : mem[head_nxt];
      end
    end
  end
endmodule

module axi_mm_a32_d128_packet_gen1_master_name (
  input logic clk_wr,
  input logic rst_wr_n,
  input logic m_gen2_mode,
  axi_mm_a32_d128_packet_gen1_master_name_if.master bus
);
  localparam int AR_W = 49;
  localparam int AW_W = 49;
  localparam int W_W  = 149;
  localparam int R_W  = 135;
  localparam int B_W  = 6;

  logic             unused_gen2_mode;
  logic [R_W-1:0]   r_word;
  logic [B_W-1:0]   b_word;

  assign unused_gen2_mode = m_gen2_mode;

  axi_mm_a32_d128_packet_gen1_master_name_skid #(.W(AR_W)) ar_skid (
    .clk      (clk_wr),
    .rst_n    (rst_wr_n),
    .up_valid (bus.user_arvalid),
    .up_ready (bus.user_arready),
    .up_data  ({bus.user_araddr, bus.user_arburst, bus.user_arlen, bus.user_arsize, bus.user_arid}),
    .dn_valid (bus.user_ar_valid),
    .dn_ready (bus.user_ar_ready),
    .dn_data  (bus.txfifo_ar_data)
  );

  axi_mm_a32_d128_packet_gen1_master_name_skid #(.W(AW_W)) aw_skid (
    .clk      (clk_wr),
    .rst_n    (rst_wr_n),
    .up_valid (bus.user_awvalid),
    .up_ready (bus.user_awready),
    .up_data  ({bus.user_awaddr, bus.user_awburst, bus.user_awlen, bus.user_awsize, bus.user_awid}),
    .dn_valid (bus.user_aw_valid),
    .dn_ready (bus.user_aw_ready),
    .dn_data  (bus.txfifo_aw_data)
  );

  axi_mm_a32_d128_packet_gen1_master_name_skid #(.W(W_W)) w_skid (
    .clk      (clk_wr),
    .rst_n    (rst_wr_n),
    .up_valid (bus.user_wvalid),
    .up_ready (bus.user_wready),
    .up_data  ({bus.user_wlast, bus.user_wstrb, bus.user_wdata, bus.user_wid}),
    .dn_valid (bus.user_w_valid),
    .dn_ready (bus.user_w_ready),
    .dn_data  (bus.txfifo_w_data)
  );

  axi_mm_a32_d128_packet_gen1_master_name_skid #(.W(R_W)) r_skid (
    .clk      (clk_wr),
    .rst_n    (rst_wr_n),
    .up_valid (bus.user_r_valid),
    .up_ready (bus.user_r_ready),
    .up_data  (bus.rxfifo_r_data),
    .dn_valid (bus.user_rvalid),
    .dn_ready (bus.user_rready),
    .dn_data  (r_word)
  );

  axi_mm_a32_d128_packet_gen1_master_name_skid #(.W(B_W)) b_skid (
    .clk      (clk_wr),
    .rst_n    (rst_wr_n),
    .up_valid (bus.user_b_valid),
    .up_ready (bus.user_b_ready),
    .up_data  (bus.rxfifo_b_data),
    .dn_valid (bus.user_bvalid),
    .dn_ready (bus.user_bready),
    .dn_data  (b_word)
  );

  // R and B unpacking is pure bit placement of the registered head word.
  assign bus.user_rid   = r_word[3:0];
  assign bus.user_rdata = r_word[131:4];
  assign bus.user_rlast = r_word[132];
  assign bus.user_rresp = r_word[134:133];
  assign bus.user_bid   = b_word[3:0];
  assign bus.user_bresp = b_word[5:4];
endmodule

// File: tb/tb_axi_mm_a32_d128_packet_gen1_master_name.sv
// Directed and scoreboarded bench for the master-side packet gen: reset, pack/unpack, backpressure,
// randomized handshakes on all five channels, and asynchronous reset with a full B buffer.
module tb_axi_mm_a32_d128_packet_gen1_master_name;
  logic clk_wr;
  logic rst_wr_n;
  logic m_gen2_mode;
  int   total_checks;
  int   bad_checks;

  axi_mm_a32_d128_packet_gen1_master_name_if bus ();

  axi_mm_a32_d128_packet_gen1_master_name dut (
    .clk_wr      (clk_wr),
    .rst_wr_n    (rst_wr_n),
    .m_gen2_mode (m_gen2_mode),
    .bus         (bus)
  );

  initial clk_wr = 1'b0;
  always #5 clk_wr = ~clk_wr;

  task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total_checks++;
    if (obs !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_wr);
    #1;
  endtask

  task automatic applyStimulus(input logic up_v, input logic dn_r);
    bus.user_arvalid  = up_v;
    bus.user_awvalid  = up_v;
    bus.user_wvalid   = up_v;
    bus.user_r_valid  = up_v;
    bus.user_b_valid  = up_v;
    bus.user_ar_ready = dn_r;
    bus.user_aw_ready = dn_r;
    bus.user_w_ready  = dn_r;
    bus.user_rready   = dn_r;
    bus.user_bready   = dn_r;
  endtask

  task automatic driveUp(input int ch, input logic v, input logic [159:0] w);
    case (ch)
      0: begin
        bus.user_arvalid = v;
        {bus.user_araddr, bus.user_arburst, bus.user_arlen, bus.user_arsize, bus.user_arid} = w[48:0];
      end
      1: begin
        bus.user_awvalid = v;
        {bus.user_awaddr, bus.user_awburst, bus.user_awlen, bus.user_awsize, bus.user_awid} = w[48:0];
      end
      2: begin
        bus.user_wvalid = v;
        {bus.user_wlast, bus.user_wstrb, bus.user_wdata, bus.user_wid} = w[148:0];
      end
      3: begin
        bus.user_r_valid  = v;
        bus.rxfifo_r_data = w[134:0];
      end
      default: begin
        bus.user_b_valid  = v;
        bus.rxfifo_b_data = w[5:0];
      end
    endcase
  endtask

  task automatic driveDn(input int ch, input logic r);
    case (ch)
      0: bus.user_ar_ready = r;
      1: bus.user_aw_ready = r;
      2: bus.user_w_ready  = r;
      3: bus.user_rready   = r;
      default: bus.user_bready = r;
    endcase
  endtask

  task automatic sampleCh(input int ch, output logic up_rdy, output logic dn_vld, output logic [159:0] dn_word);
    case (ch)
      0: begin up_rdy = bus.user_arready; dn_vld = bus.user_ar_valid; dn_word = 160'(bus.txfifo_ar_data); end
      1: begin up_rdy = bus.user_awready; dn_vld = bus.user_aw_valid; dn_word = 160'(bus.txfifo_aw_data); end
      2: begin up_rdy = bus.user_wready;  dn_vld = bus.user_w_valid;  dn_word = 160'(bus.txfifo_w_data); end
      3: begin
        up_rdy  = bus.user_r_ready;
        dn_vld  = bus.user_rvalid;
        dn_word = 160'({bus.user_rresp, bus.user_rlast, bus.user_rdata, bus.user_rid});
      end
      default: begin
        up_rdy  = bus.user_b_ready;
        dn_vld  = bus.user_bvalid;
        dn_word = 160'({bus.user_bresp, bus.user_bid});
      end
    endcase
  endtask

  function automatic logic [159:0] wBeat(input int k);
    logic [127:0] data;
    data = {4{32'hA000_0000 | 32'(k)}};
    return 160'({(k == 4), 16'hF0F0 ^ 16'(k), data, 4'h2});
  endfunction

  logic [159:0] ring [5][8];
  int           wp [5];
  int           rp [5];
  logic         upv [5];
  logic [159:0] upw [5];
  logic         dnr [5];
  logic         hold [5];
  logic         pending [5];
  logic [159:0] held_word [5];
  int           chan_w [5];

  initial begin
    logic         ur;
    logic         dv;
    logic [159:0] dw;
    logic [159:0] mask;
    logic         acc;
    total_checks = 0;
    bad_checks   = 0;
    m_gen2_mode  = 1'b0;
    chan_w[0] = 49; chan_w[1] = 49; chan_w[2] = 149; chan_w[3] = 135; chan_w[4] = 6;
    for (int c = 0; c < 5; c++) driveUp(c, 1'b1, 160'h0);
    applyStimulus(1'b1, 1'b1);
    rst_wr_n = 1'b1;
    #2 rst_wr_n = 1'b0;

    // Reset with every valid asserted
    repeat (5) tick();
    checkOutput("rst_readys", 160'({bus.user_arready, bus.user_awready, bus.user_wready,
                                    bus.user_r_ready, bus.user_b_ready}), 160'd0);
    checkOutput("rst_valids", 160'({bus.user_ar_valid, bus.user_aw_valid, bus.user_w_valid,
                                    bus.user_rvalid, bus.user_bvalid}), 160'd0);
    checkOutput("rst_w_data", 160'(bus.txfifo_w_data), 160'd0);
    rst_wr_n = 1'b1;
    tick();
    checkOutput("rel_readys", 160'({bus.user_arready, bus.user_awready, bus.user_wready,
                                    bus.user_r_ready, bus.user_b_ready}), 160'h1F);
    checkOutput("rel_valids", 160'({bus.user_ar_valid, bus.user_aw_valid, bus.user_w_valid,
                                    bus.user_rvalid, bus.user_bvalid}), 160'd0);
    applyStimulus(1'b0, 1'b1);

    // AR pack and hold under backpressure
    bus.user_ar_ready = 1'b0;
    bus.user_arid = 4'd3; bus.user_arsize = 3'd4; bus.user_arlen = 8'h0F;
    bus.user_arburst = 2'd1; bus.user_araddr = 32'h1234_5678; bus.user_arvalid = 1'b1;
    tick();
    checkOutput("ar_valid", 160'(bus.user_ar_valid), 160'd1);
    checkOutput("ar_data", 160'(bus.txfifo_ar_data), 160'h02468ACF087C3);
    checkOutput("ar_ready_c1", 160'(bus.user_arready), 160'd1);
    bus.user_arvalid = 1'b0;
    tick();
    checkOutput("ar_hold_v", 160'(bus.user_ar_valid), 160'd1);
    checkOutput("ar_hold_d", 160'(bus.txfifo_ar_data), 160'h02468ACF087C3);
    bus.user_ar_ready = 1'b1;
    tick();
    checkOutput("ar_drained", 160'(bus.user_ar_valid), 160'd0);

    // W backpressure: two beats fill the buffer, the rest flow once the link is ready
    bus.user_w_ready = 1'b0;
    driveUp(2, 1'b1, wBeat(1));
    tick();
    checkOutput("w_ready_c1", 160'(bus.user_wready), 160'd1);
    driveUp(2, 1'b1, wBeat(2));
    tick();
    checkOutput("w_ready_full", 160'(bus.user_wready), 160'd0);
    checkOutput("w_head1", 160'(bus.txfifo_w_data), wBeat(1));
    driveUp(2, 1'b1, wBeat(3));
    tick();
    checkOutput("w_still_full", 160'(bus.user_wready), 160'd0);
    checkOutput("w_head1_held", 160'(bus.txfifo_w_data), wBeat(1));
    bus.user_w_ready = 1'b1;
    tick();
    checkOutput("w_beat2_v", 160'(bus.user_w_valid), 160'd1);
    checkOutput("w_beat2", 160'(bus.txfifo_w_data), wBeat(2));
    checkOutput("w_ready_back", 160'(bus.user_wready), 160'd1);
    tick();
    checkOutput("w_beat3_v", 160'(bus.user_w_valid), 160'd1);
    checkOutput("w_beat3", 160'(bus.txfifo_w_data), wBeat(3));
    driveUp(2, 1'b1, wBeat(4));
    tick();
    checkOutput("w_beat4_v", 160'(bus.user_w_valid), 160'd1);
    checkOutput("w_beat4", 160'(bus.txfifo_w_data), wBeat(4));
    checkOutput("w_last4", 160'(bus.txfifo_w_data[148]), 160'd1);
    bus.user_wvalid = 1'b0;
    tick();
    checkOutput("w_empty", 160'(bus.user_w_valid), 160'd0);

    // R unpack
    bus.rxfifo_r_data = {2'b10, 1'b1, 128'hDEADBEEF0, 4'd5};
    bus.user_r_valid  = 1'b1;
    tick();
    bus.user_r_valid = 1'b0;
    checkOutput("r_valid", 160'(bus.user_rvalid), 160'd1);
    checkOutput("r_id", 160'(bus.user_rid), 160'd5);
    checkOutput("r_data", 160'(bus.user_rdata), 160'hDEADBEEF0);
    checkOutput("r_last", 160'(bus.user_rlast), 160'd1);
    checkOutput("r_resp", 160'(bus.user_rresp), 160'd2);
    tick();
    checkOutput("r_drained", 160'(bus.user_rvalid), 160'd0);

    // Random handshakes on all channels against a per-channel scoreboard, then a drain phase
    for (int c = 0; c < 5; c++) begin
      wp[c] = 0; rp[c] = 0; hold[c] = 1'b0; pending[c] = 1'b0;
      upv[c] = 1'b0; upw[c] = '0; held_word[c] = '0;
    end
    for (int cyc = 0; cyc < 10020; cyc++) begin
      for (int c = 0; c < 5; c++) begin
        sampleCh(c, ur, dv, dw);
        if (hold[c]) begin
          checkOutput($sformatf("stable_v%0d", c), 160'(dv), 160'd1);
          checkOutput($sformatf("stable_d%0d", c), dw, held_word[c]);
        end
        if (!pending[c]) begin
          mask   = (160'd1 << chan_w[c]) - 160'd1;
          upv[c] = (cyc < 10000) && ($urandom_range(99) < 60);
          upw[c] = {$urandom, $urandom, $urandom, $urandom, $urandom} & mask;
        end
        dnr[c] = (cyc >= 10000) || ($urandom_range(99) < 70);
        driveUp(c, upv[c], upw[c]);
        driveDn(c, dnr[c]);
        acc = upv[c] & ur;
        if (acc) begin
          ring[c][wp[c] % 8] = upw[c];
          wp[c]++;
        end
        pending[c] = upv[c] & ~acc;
        if (dv && dnr[c]) begin
          checkOutput($sformatf("sb_nonempty%0d", c), 160'(rp[c] != wp[c] || acc), 160'd1);
          if (rp[c] != wp[c]) begin
            checkOutput($sformatf("sb_data%0d", c), dw, ring[c][rp[c] % 8]);
            rp[c]++;
          end
        end
        hold[c]      = dv & ~dnr[c];
        held_word[c] = dw;
      end
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("sb_drain%0d", c), 160'(rp[c]), 160'(wp[c]));
    end
    applyStimulus(1'b0, 1'b1);

    // B buffer full, then asynchronous reset mid-cycle
    bus.user_bready = 1'b0;
    driveUp(4, 1'b1, 160'h2A);
    tick();
    driveUp(4, 1'b1, 160'h15);
    tick();
    bus.user_b_valid = 1'b0;
    checkOutput("b_full_v", 160'(bus.user_bvalid), 160'd1);
    checkOutput("b_full_rdy", 160'(bus.user_b_ready), 160'd0);
    checkOutput("b_head", 160'({bus.user_bresp, bus.user_bid}), 160'h2A);
    #3 rst_wr_n = 1'b0;
    #1;
    checkOutput("b_async_v", 160'(bus.user_bvalid), 160'd0);
    checkOutput("b_async_d", 160'({bus.user_bresp, bus.user_bid}), 160'd0);
    @(negedge clk_wr);
    rst_wr_n = 1'b1;
    bus.user_bready = 1'b1;
    tick();
    checkOutput("b_rel_rdy", 160'(bus.user_b_ready), 160'd1);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("b_no_stale%0d", k), 160'(bus.user_bvalid), 160'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end
endmodule
